dadda_mul_arbiter: RTL
======================

Name: dadda_mul_arbiter

Overview:
Shares one combinational dadda_multiplier_8_bits instance among NUM_REQ requesters, each using a valid/ready request interface. Round-robin arbitration picks a requester. The block registers the winner's operands, captures the 16-bit product one cycle later, and presents it on a single response channel with the requester ID. It sits between the processing lanes and the shared multiplier datapath, and one transaction is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ), minimum 1.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
req_a  in  NUM_REQ*8  operand A, requester i at bits [8i+7:8i].
req_b  in  NUM_REQ*8  operand B, same packing.
rsp_valid  out  1  product valid.
rsp_ready  in  1  consumer accepts the product.
rsp_id  out  ID_W  index of the requester that owns rsp_product.
rsp_product  out  16  a*b, unsigned.
busy  out  1  high whenever state is not IDLE.
ovf_err  out  1  sticky: the multiplier's bit 16 was seen at 1.

Behaviour:
- Reset, sampled on a rising edge with rst=1, sets: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_product=0, ovf_err=0, operand registers=0.
- During rst=1, req_ready=0 for all requesters.
- FSM states: IDLE, MUL, HOLD.
- IDLE:
  - If any req_valid is high, the grant is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in that same cycle; this is the handshake.
  - At the edge: op_a/op_b/op_id <= requester's a/b/grant; rr_ptr <= (grant+1) mod NUM_REQ; state -> MUL.
  - If no req_valid is high, stay in IDLE with rr_ptr unchanged.
- MUL:
  - The multiplier sees op_a/op_b.
  - At the edge: rsp_product <= out[15:0]; rsp_id <= op_id; rsp_valid <= 1; ovf_err <= ovf_err | out[16]; state -> HOLD.
- HOLD:
  - rsp_valid=1; rsp_product and rsp_id are held stable.
  - If rsp_ready=1, then at the edge rsp_valid <= 0 and state -> IDLE.
  - A new request is not accepted in the same cycle; it is first accepted in the following IDLE cycle.
- req_ready is only ever asserted in IDLE.
- Latency: accept in cycle T; rsp_valid is high from cycle T+2.
- Throughput: 1 transaction per 3 cycles when rsp_ready is held high.
- Requester rules:
  - A requester must hold a/b stable while req_valid=1 until it sees req_ready.
  - Dropping req_valid before the grant is legal; the requester simply loses its turn.
- Boundaries:
  - Simultaneous requests: strict rotation, so no requester waits more than NUM_REQ grants.
  - rr_ptr wrap: from NUM_REQ-1 it goes to 0.
  - Reset in MUL or HOLD: the transaction is discarded, and rsp_valid is 0 in the cycle after the reset edge.
  - rsp_ready=1 in IDLE or MUL: ignored.
  - rsp_ready low indefinitely: the block stays in HOLD with outputs stable.
- Arithmetic: unsigned 8x8 -> 16 bits. out[16] should never be 1; ovf_err flags a datapath fault.

Decomposition:
- Package dadda_arb_pkg holds: state enum (IDLE, MUL, HOLD); OP_W=8; PROD_W=16; MUL_OUT_W=17.
- Sub-module rr_arbiter: inputs req[NUM_REQ] and ptr[ID_W]; outputs a one-hot grant and grant_idx. It is purely combinational.
- The top level instantiates rr_arbiter and dadda_multiplier_8_bits unchanged.

Test Plan:
- Single request: requester 0 with a=200, b=150, rsp_ready=1. Expect req_ready[0] high for exactly 1 cycle at T; rsp_valid at T+2 with rsp_product=30000 (0x7530), rsp_id=0.
- Corners:
  - 255*255 gives 65025 (0xFE01).
  - 0*173 gives 0.
  - 1*255 gives 255.
  - ovf_err stays 0 throughout.
- All four req_valid held high, with each requester dropping its valid after its grant. Expect grants in order 0,1,2,3; rr_ptr back to 0; responses every 3 cycles with rsp_id 0,1,2,3.
- Backpressure: rsp_ready=0 for 5 cycles in HOLD. rsp_product/rsp_id stay stable and req_ready stays 0 throughout. After rsp_ready=1, the next grant comes exactly 1 cycle after the transfer cycle.
- Reset mid-operation: assert rst in the MUL cycle. The next cycle shows rsp_valid=0, busy=0, rr_ptr=0; a subsequent request from requester 2 completes normally with rsp_id=2.
- Random: 2000 random valid/operand/rsp_ready patterns against a golden a*b model with fairness checks. Expected results:
  - every accepted request gets exactly one response with the correct product;
  - no requester is starved beyond NUM_REQ grants.

Source files
------------

// File: rtl/dadda_arb_pkg.sv
// Shared types and widths for the multiplier arbiter.
package dadda_arb_pkg;

    localparam int unsigned OP_W      = 8;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned MUL_OUT_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/dadda_multiplier_8_bits.sv
// Combinational unsigned 8x8 multiplier: partial products reduced by
// 3:2 compressor stages (8 -> 6 -> 4 -> 3 -> 2 rows), then one final add.
module dadda_multiplier_8_bits (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [16:0] out
);

    // Carry vector of a 3:2 compressor, already weighted by one position.
    function automatic logic [16:0] csa_carry(input logic [16:0] x, input logic [16:0] y,
                                              input logic [16:0] z);
        logic [16:0] m;
        m = (x & y) | (x & z) | (y & z);
        return m << 1;
    endfunction

    logic [16:0] w_pp [8];
    logic [16:0] w_s1 [6];
    logic [16:0] w_s2 [4];
    logic [16:0] w_s3 [3];
    logic [16:0] w_s4 [2];

    // Partial product rows, row i weighted by 2^i.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_pp[i] = {9'd0, a & {8{b[i]}}} << i;
        end
    end

    // Reduction tree; every row stays below 2^16 so the dropped carry bit is always zero.
    always_comb begin
        w_s1[0] = w_pp[0] ^ w_pp[1] ^ w_pp[2];
        w_s1[1] = csa_carry(w_pp[0], w_pp[1], w_pp[2]);
        w_s1[2] = w_pp[3] ^ w_pp[4] ^ w_pp[5];
        w_s1[3] = csa_carry(w_pp[3], w_pp[4], w_pp[5]);
        w_s1[4] = w_pp[6];
        w_s1[5] = w_pp[7];

        w_s2[0] = w_s1[0] ^ w_s1[1] ^ w_s1[2];
        w_s2[1] = csa_carry(w_s1[0], w_s1[1], w_s1[2]);
        w_s2[2] = w_s1[3] ^ w_s1[4] ^ w_s1[5];
        w_s2[3] = csa_carry(w_s1[3], w_s1[4], w_s1[5]);

        w_s3[0] = w_s2[0] ^ w_s2[1] ^ w_s2[2];
        w_s3[1] = csa_carry(w_s2[0], w_s2[1], w_s2[2]);
        w_s3[2] = w_s2[3];

        w_s4[0] = w_s3[0] ^ w_s3[1] ^ w_s3[2];
        w_s4[1] = csa_carry(w_s3[0], w_s3[1], w_s3[2]);
    end

    // Final carry-propagate add.
    always_comb begin
        out = w_s4[0] + w_s4[1];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // Scan from the farthest position back to ptr so the closest hit wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                grant     = NUM_REQ'(1) << idx;
                grant_idx = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Shares one combinational multiplier among NUM_REQ valid/ready requesters.
// One transaction in flight: IDLE (accept) -> MUL (compute) -> HOLD (respond).
module dadda_mul_arbiter
    import dadda_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [PROD_W-1:0]       rsp_product,
    output logic                    busy,
    output logic                    ovf_err
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_op_id;
    logic [OP_W-1:0]        r_op_a;
    logic [OP_W-1:0]        r_op_b;
    logic                   r_rsp_valid;
    logic [ID_W-1:0]        r_rsp_id;
    logic [PROD_W-1:0]      r_rsp_product;
    logic                   r_ovf_err;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_any;
    logic [ID_W-1:0]        w_ptr_next;
    logic [OP_W-1:0]        w_sel_a;
    logic [OP_W-1:0]        w_sel_b;
    logic [MUL_OUT_W-1:0]   w_mul_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    dadda_multiplier_8_bits u_mul (
        .a   (r_op_a),
        .b   (r_op_b),
        .out (w_mul_out)
    );

    // Winner's operands and the pointer value that follows it.
    always_comb begin
        w_any      = |req_valid;
        w_sel_a    = req_a[w_grant_idx * OP_W +: OP_W];
        w_sel_b    = req_b[w_grant_idx * OP_W +: OP_W];
        w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = MUL;
            MUL:     w_state_next = HOLD;
            HOLD:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake and status outputs; accepting is blocked while reset is applied.
    always_comb begin
        req_ready   = ((r_state == IDLE) && !rst) ? w_grant : '0;
        busy        = (r_state != IDLE);
        rsp_valid   = r_rsp_valid;
        rsp_id      = r_rsp_id;
        rsp_product = r_rsp_product;
        ovf_err     = r_ovf_err;
    end

    // Datapath: capture operands on accept, product after one cycle, release on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_op_id       <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
            r_ovf_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_op_id  <= w_grant_idx;
                        r_rr_ptr <= w_ptr_next;
                    end
                end
                MUL: begin
                    r_rsp_product <= w_mul_out[PROD_W-1:0];
                    r_rsp_id      <= r_op_id;
                    r_rsp_valid   <= 1'b1;
                    // Bit 16 of an 8x8 product can only be set by a datapath fault.
                    r_ovf_err     <= r_ovf_err | w_mul_out[MUL_OUT_W-1];
                end
                HOLD: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
